// File: rtl/cla_pipe_add.sv
// rtl/cla_pipe_add.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
// Optional signed-overflow output built only when CLA_PIPE_OVF_EN is defined.
module cla_pipe_add #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;
  localparam int NG    = SLICE / 8;

  // Returns {carry into MSB, carry out, sum}; two-level lookahead over 8-bit groups.
  function automatic logic [SLICE+1:0] f_slice(input logic [SLICE-1:0] fa,
                                               input logic [SLICE-1:0] fb,
                                               input logic             fcin);
    logic [SLICE-1:0] g, p, c;
    logic [NG-1:0]    gg, gp;
    logic [NG:0]      gc;
    logic             tp, cy;
    g = fa & fb;
    p = fa ^ fb;
    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        gg[k] = g[8*k+i] | (p[8*k+i] & gg[k]);
        gp[k] = gp[k] & p[8*k+i];
      end
    end
    gc[0] = fcin;
    for (int k = 0; k < NG; k++) begin
      cy = 1'b0;
      tp = 1'b1;
      for (int j = k; j >= 0; j--) begin
        cy = cy | (gg[j] & tp);
        tp = tp & gp[j];
      end
      gc[k+1] = cy | (tp & fcin);
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 8; i++) begin
        cy = 1'b0;
        tp = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          cy = cy | (g[8*k+j] & tp);
          tp = tp & p[8*k+j];
        end
        c[8*k+i] = cy | (tp & gc[k]);
      end
    end
    return {c[SLICE-1], gc[NG], p ^ c};
  endfunction

  logic              w_adv;
  logic [WIDTH-1:0]  w_binv;
  logic              w_cin0;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_cin;
  logic [WIDTH-1:0]  w_a_in [STAGES];
  logic [WIDTH-1:0]  w_b_in [STAGES];
  logic [WIDTH-1:0]  w_s_in [STAGES];
  logic [SLICE+1:0]  w_res  [STAGES];
  logic              r_v    [STAGES];
  logic              r_cy   [STAGES];
  logic [WIDTH-1:0]  r_a    [STAGES];
  logic [WIDTH-1:0]  r_b    [STAGES];
  logic [WIDTH-1:0]  r_s    [STAGES];

  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;
  assign w_binv   = b ^ {WIDTH{op_sub}};
  assign w_cin0   = c_in | op_sub;

  // Level j adds slice j; lower sum bits ride along, upper operand bits wait their turn.
  for (genvar j = 0; j < STAGES; j++) begin : g_lvl
    logic w_unused;
    if (j == 0) begin : g_head
      assign w_vin[j]  = in_valid;
      assign w_cin[j]  = w_cin0;
      assign w_a_in[j] = a;
      assign w_b_in[j] = w_binv;
      assign w_s_in[j] = '0;
    end else begin : g_body
      assign w_vin[j]  = r_v[j-1];
      assign w_cin[j]  = r_cy[j-1];
      assign w_a_in[j] = r_a[j-1];
      assign w_b_in[j] = r_b[j-1];
      assign w_s_in[j] = r_s[j-1];
    end
    assign w_res[j] = f_slice(w_a_in[j][j*SLICE +: SLICE], w_b_in[j][j*SLICE +: SLICE], w_cin[j]);
    assign w_unused = ^{r_a[j], r_b[j], w_res[j]};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v[j]  <= 1'b0;
        r_cy[j] <= 1'b0;
        r_a[j]  <= '0;
        r_b[j]  <= '0;
        r_s[j]  <= '0;
      end else if (w_adv) begin
        r_v[j] <= w_vin[j];
        if (w_vin[j]) begin
          r_a[j] <= w_a_in[j];
          r_b[j] <= w_b_in[j];
          r_s[j] <= w_s_in[j];
          r_s[j][j*SLICE +: SLICE] <= w_res[j][SLICE-1:0];
          r_cy[j] <= w_res[j][SLICE];
        end
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign s         = r_s[STAGES-1];
  assign c_out     = r_cy[STAGES-1];

`ifdef CLA_PIPE_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_adv && w_vin[STAGES-1])
      r_ovf <= w_res[STAGES-1][SLICE+1] ^ w_res[STAGES-1][SLICE];
  end
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_cla_pipe_add.sv
// tb/tb_cla_pipe_add.sv - randomized self-checking bench for cla_pipe_add
module tb_cla_pipe_add;
`ifdef CLA_PIPE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, c_in, op_sub, out_valid, out_ready, c_out, ovf;
  logic [31:0] a, b, s;

  logic [63:0] sw_a, sw_b;
  logic        sw_ci, sw_sub, sw_iv;
  logic [2:0]  sw_ir, sw_ov, sw_c, sw_o;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic [63:0] s64;
  logic [63:0] sw_s [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [65:0] sb_q [$];
  int          cyc_q [$];
  logic        ob_v, ob_ir, ob_c, ob_o, ob_acc, ob_xfer, ob_have;
  logic [31:0] ob_s;
  logic [65:0] ob_ex;
  int          ob_lat;

  cla_pipe_add #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf));

  cla_pipe_add #(.WIDTH(8), .STAGES(1)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(sw_ir[0]), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .c_in(sw_ci), .op_sub(sw_sub), .out_valid(sw_ov[0]), .out_ready(1'b1),
    .s(s8), .c_out(sw_c[0]), .ovf(sw_o[0]));

  cla_pipe_add #(.WIDTH(32), .STAGES(4)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(sw_ir[1]), .a(sw_a[31:0]), .b(sw_b[31:0]),
    .c_in(sw_ci), .op_sub(sw_sub), .out_valid(sw_ov[1]), .out_ready(1'b1),
    .s(s32), .c_out(sw_c[1]), .ovf(sw_o[1]));

  cla_pipe_add #(.WIDTH(64), .STAGES(2)) u_s64 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(sw_ir[2]), .a(sw_a), .b(sw_b),
    .c_in(sw_ci), .op_sub(sw_sub), .out_valid(sw_ov[2]), .out_ready(1'b1),
    .s(s64), .c_out(sw_c[2]), .ovf(sw_o[2]));

  assign sw_s[0] = {56'd0, s8};
  assign sw_s[1] = {32'd0, s32};
  assign sw_s[2] = s64;

  // Reference: plain W-bit arithmetic; returns {ovf, carry out, sum}.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] ra, input logic [63:0] rb,
                                         input logic rci, input logic rsub);
    logic [63:0] m, aa, bb;
    logic [64:0] full;
    logic        ov;
    m    = {64{1'b1}} >> (64 - w);
    aa   = ra & m;
    bb   = (rsub ? ~rb : rb) & m;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, (rsub | rci)};
    ov   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    if (!OVF_ON) ov = 1'b0;
    return {ov, full[w], full[63:0] & m};
  endfunction

  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic ci, input logic sub, input logic orr);
    in_valid = iv; a = ia; b = ib; c_in = ci; op_sub = sub; out_ready = orr;
    #1;
    ob_v = out_valid; ob_ir = in_ready; ob_s = s; ob_c = c_out; ob_o = ovf;
    ob_xfer = out_valid && orr;
    ob_acc  = iv && in_ready;
    ob_have = 1'b0;
    if (ob_xfer && sb_q.size() > 0) begin
      ob_ex   = sb_q.pop_front();
      ob_lat  = cyc - cyc_q.pop_front();
      ob_have = 1'b1;
    end
    if (ob_acc) begin
      sb_q.push_back(ref_op(32, {32'd0, ia}, {32'd0, ib}, ci, sub));
      cyc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (s !== 32'd0) begin n_fail++; $display("FAIL reset_s: got %h want 0", s); end
    n_tests++; if (c_out !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got c=%b o=%b want 0 0", c_out, ovf); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (ob_v !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: out_valid got %b want 0", ob_v); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4];
    logic [31:0] tbv [4];
    logic [31:0] es [4];
    logic        tci [4];
    logic        tsub [4];
    logic        ec [4];
    logic        eo [4];
    int n_iss = 0;
    int n_got = 0;
    int idx;
    ta   = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
    tbv  = '{32'd1, 32'd1, 32'd7, 32'd1};
    tci  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tsub = '{1'b0, 1'b0, 1'b1, 1'b1};
    es   = '{32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    ec   = '{1'b0, 1'b1, 1'b0, 1'b1};
    eo   = '{1'b0, 1'b0, 1'b0, OVF_ON};
    for (int t = 0; t < 16; t++) begin
      idx = (n_iss < 4) ? n_iss : 0;
      step(n_iss < 4, ta[idx], tbv[idx], tci[idx], tsub[idx], 1'b1);
      if (ob_acc) n_iss++;
      if (ob_xfer) begin
        n_tests++;
        if (n_got >= 4) begin
          n_fail++; $display("FAIL directed_spurious: extra result s=%h", ob_s);
        end else if (ob_s !== es[n_got] || ob_c !== ec[n_got] || ob_o !== eo[n_got]) begin
          n_fail++;
          $display("FAIL directed_%0d: got s=%h c=%b o=%b want s=%h c=%b o=%b",
                   n_got, ob_s, ob_c, ob_o, es[n_got], ec[n_got], eo[n_got]);
        end
        if (ob_have) begin
          n_tests++; if (ob_lat !== 2) begin n_fail++; $display("FAIL directed_latency: got %0d want 2", ob_lat); end
        end
        n_got++;
      end
    end
    n_tests++; if (n_got !== 4) begin n_fail++; $display("FAIL directed_count: got %0d want 4", n_got); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ca, cb, ps;
    logic        cci, csub, orr, pc, po, prev_stall;
    int n_iss = 0;
    int n_got = 0;
    ca = $urandom; cb = $urandom; cci = 1'($urandom_range(0, 1)); csub = 1'($urandom_range(0, 1));
    prev_stall = 1'b0; ps = '0; pc = 1'b0; po = 1'b0;
    for (int t = 0; t < 20; t++) begin
      orr = !(t >= 3 && t <= 5);
      step(n_iss < 6, ca, cb, cci, csub, orr);
      if (ob_v && !orr) begin
        n_tests++; if (ob_ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0 at t=%0d", ob_ir, t); end
      end
      if (prev_stall) begin
        n_tests++;
        if (ob_v !== 1'b1 || ob_s !== ps || ob_c !== pc || ob_o !== po) begin
          n_fail++; $display("FAIL bp_hold: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b", ob_v, ob_s, ob_c, ob_o, ps, pc, po);
        end
      end
      prev_stall = ob_v && !orr; ps = ob_s; pc = ob_c; po = ob_o;
      if (ob_acc) begin
        n_iss++;
        ca = $urandom; cb = $urandom; cci = 1'($urandom_range(0, 1)); csub = 1'($urandom_range(0, 1));
      end
      if (ob_xfer) begin
        n_tests++;
        if (!ob_have || ob_s !== ob_ex[31:0] || ob_c !== ob_ex[64] || ob_o !== ob_ex[65]) begin
          n_fail++; $display("FAIL bp_result: got s=%h c=%b o=%b want s=%h c=%b o=%b (have=%b)",
                             ob_s, ob_c, ob_o, ob_ex[31:0], ob_ex[64], ob_ex[65], ob_have);
        end
        n_got++;
      end
    end
    n_tests++; if (n_got !== 6 || sb_q.size() !== 0) begin n_fail++; $display("FAIL bp_count: got %0d left %0d want 6 left 0", n_got, sb_q.size()); end
  endtask

  task automatic test_bubbles();
    logic hv [24];
    logic iv, expv;
    for (int t = 0; t < 24; t++) begin
      iv = (t % 2 == 0) && (t < 16);
      hv[t] = iv;
      step(iv, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      expv = (t >= 2) ? hv[t-2] : 1'b0;
      n_tests++; if (ob_v !== expv) begin n_fail++; $display("FAIL bubble_valid: got %b want %b at t=%0d", ob_v, expv, t); end
      if (ob_xfer) begin
        n_tests++;
        if (!ob_have || ob_s !== ob_ex[31:0] || ob_c !== ob_ex[64] || ob_o !== ob_ex[65] || ob_lat !== 2) begin
          n_fail++; $display("FAIL bubble_result: got s=%h c=%b o=%b lat=%0d want s=%h c=%b o=%b lat=2",
                             ob_s, ob_c, ob_o, ob_lat, ob_ex[31:0], ob_ex[64], ob_ex[65]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 3; t++) begin
      step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      if (ob_xfer) begin
        n_tests++;
        if (!ob_have || ob_s !== ob_ex[31:0] || ob_c !== ob_ex[64]) begin
          n_fail++; $display("FAIL pre_reset_result: got s=%h c=%b want s=%h c=%b", ob_s, ob_c, ob_ex[31:0], ob_ex[64]);
        end
      end
    end
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_tests++; if (s !== 32'd0 || c_out !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got s=%h c=%b o=%b want 0", s, c_out, ovf); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    sb_q.delete();
    cyc_q.delete();
    for (int t = 0; t < 6; t++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (ob_v !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost: out_valid got %b want 0 at t=%0d", ob_v, t); end
    end
  endtask

  task automatic test_sweep();
    logic [63:0] ha [1000];
    logic [63:0] hb [1000];
    logic        hc [1000];
    logic        hs [1000];
    int          ws [3];
    int          ls [3];
    logic [65:0] ex;
    logic        expv;
    int          k;
    ws = '{8, 32, 64};
    ls = '{1, 4, 2};
    for (int i = 0; i < 1006; i++) begin
      if (i < 1000) begin
        ha[i] = {$urandom, $urandom};
        hb[i] = ($urandom_range(0, 7) == 0) ? ~ha[i] : {$urandom, $urandom};
        hc[i] = 1'($urandom_range(0, 1));
        hs[i] = 1'($urandom_range(0, 1));
        sw_a = ha[i]; sw_b = hb[i]; sw_ci = hc[i]; sw_sub = hs[i]; sw_iv = 1'b1;
      end else begin
        sw_iv = 1'b0;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        k = i - ls[d];
        expv = (k >= 0) && (k < 1000);
        n_tests++; if (sw_ov[d] !== expv) begin n_fail++; $display("FAIL sweep_valid_w%0d: got %b want %b at i=%0d", ws[d], sw_ov[d], expv, i); end
        n_tests++; if (sw_ir[d] !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready_w%0d: got %b want 1", ws[d], sw_ir[d]); end
        if (expv) begin
          ex = ref_op(ws[d], ha[k], hb[k], hc[k], hs[k]);
          n_tests++;
          if (sw_s[d] !== ex[63:0] || sw_c[d] !== ex[64] || sw_o[d] !== ex[65]) begin
            n_fail++; $display("FAIL sweep_result_w%0d: got s=%h c=%b o=%b want s=%h c=%b o=%b at i=%0d",
                               ws[d], sw_s[d], sw_c[d], sw_o[d], ex[63:0], ex[64], ex[65], i);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
    sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0; sw_iv = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
